traffic_light_n: RTL

TRAFFIC_LIGHT_N -- requirements
Module: traffic_light_n

---
 rtl/traffic_light_n.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_n.sv
// Multi-direction traffic light controller with sensor-driven phase
// skipping, green extension, a freeze input and per-direction BCD timers.
//
// Parameters:
//   NUM_DIR  (2..4)      number of approach directions
//   GREEN_T  (1..99)     green phase length in time units
//   YELLOW_T (1..99)     yellow phase length in time units
//   ALLRED_T (1..99)     all-red clearance length in time units
//   TICK_DIV (1..65536)  Clk cycles per time unit
//
// Ports:
//   Clk     in   rising-edge clock
//   R       in   synchronous active-high reset (overrides HOLD)
//   SENSE   in   [NUM_DIR]   vehicle-present request per direction
//   HOLD    in   freeze prescaler, timer, state and lamps
//   GREEN   out  [NUM_DIR]   green lamp per direction
//   YELLOW  out  [NUM_DIR]   yellow lamp per direction
//   RED     out  [NUM_DIR]   red lamp per direction
//   TIME_L  out  [4*NUM_DIR] BCD units of remaining time, nibble i = dir i
//   TIME_H  out  [4*NUM_DIR] BCD tens of remaining time, same packing
//   ACTIVE  out  [2]         current or most recent non-red direction
module traffic_light_n #(
    parameter int NUM_DIR  = 2,
    parameter int GREEN_T  = 30,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 1,
    parameter int TICK_DIV = 1
) (
    input  logic                   Clk,
    input  logic                   R,
    input  logic [NUM_DIR-1:0]     SENSE,
    input  logic                   HOLD,
    output logic [NUM_DIR-1:0]     GREEN,
    output logic [NUM_DIR-1:0]     YELLOW,
    output logic [NUM_DIR-1:0]     RED,
    output logic [4*NUM_DIR-1:0]   TIME_L,
    output logic [4*NUM_DIR-1:0]   TIME_H,
    output logic [1:0]             ACTIVE
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);
    localparam logic [6:0]  GT      = 7'(GREEN_T);
    localparam logic [6:0]  YT      = 7'(YELLOW_T);
    localparam logic [6:0]  AT      = 7'(ALLRED_T);

    // Lamp and digit images loaded by reset: GREEN(0) with GREEN_T shown.
    localparam logic [NUM_DIR-1:0]   RST_G  = NUM_DIR'(1);
    localparam logic [NUM_DIR-1:0]   RST_R  = ~RST_G;
    localparam logic [4*NUM_DIR-1:0] RST_TL = (4*NUM_DIR)'(GREEN_T % 10);
    localparam logic [4*NUM_DIR-1:0] RST_TH = (4*NUM_DIR)'(GREEN_T / 10);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_rem;
    logic [6:0]  w_rem_nxt;
    logic [1:0]  r_active;
    logic [1:0]  w_active_nxt;
    logic [15:0] r_pre;
    logic [15:0] w_pre_nxt;
    logic        w_tick;

    logic [NUM_DIR-1:0] w_self;
    logic               w_others;
    logic [3:0]         w_sense4;
    logic [1:0]         w_next_dir;

    logic [NUM_DIR-1:0]   w_green;
    logic [NUM_DIR-1:0]   w_yellow;
    logic [NUM_DIR-1:0]   w_red;
    logic [4*NUM_DIR-1:0] w_tl;
    logic [4*NUM_DIR-1:0] w_th;
    logic [3:0]           w_tens;
    logic [3:0]           w_units;

    assign w_tick   = (r_pre == PRE_MAX);
    assign w_sense4 = 4'(SENSE);

    always_comb begin
        w_self = '0;
        for (int k = 0; k < NUM_DIR; k++) begin
            w_self[k] = (2'(k) == r_active);
        end
    end

    // Any request from a direction other than the one holding green.
    assign w_others = |(SENSE & ~w_self);

    // Cyclic search i+1 .. i+NUM_DIR-1 for the first requesting direction;
    // falls back to (i+1) mod NUM_DIR when nobody is waiting.
    always_comb begin
        logic [2:0] w_cand;
        logic       w_found;
        w_cand     = '0;
        w_found    = 1'b0;
        w_next_dir = '0;
        for (int k = 1; k < NUM_DIR; k++) begin
            w_cand = {1'b0, r_active} + 3'(k);
            if (w_cand >= 3'(NUM_DIR)) begin
                w_cand = w_cand - 3'(NUM_DIR);
            end
            if (k == 1) begin
                w_next_dir = w_cand[1:0];
            end
            if (!w_found && w_sense4[w_cand[1:0]]) begin
                w_found    = 1'b1;
                w_next_dir = w_cand[1:0];
            end
        end
    end

    // Phase sequencing. A phase ends on the tick that finds REM==1, so a
    // phase loaded with N lasts exactly N ticks.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_active_nxt = r_active;
        w_pre_nxt    = r_pre;
        if (!HOLD) begin
            w_pre_nxt = w_tick ? 16'd0 : r_pre + 16'd1;
            if (w_tick) begin
                if (r_rem > 7'd1) begin
                    w_rem_nxt = r_rem - 7'd1;
                end else begin
                    unique case (r_state)
                        ST_GREEN: begin
                            if (w_others) begin
                                w_state_nxt = ST_YELLOW;
                                w_rem_nxt   = YT;
                            end else begin
                                w_rem_nxt   = GT;
                            end
                        end
                        ST_YELLOW: begin
                            w_state_nxt = ST_ALLRED;
                            w_rem_nxt   = AT;
                        end
                        ST_ALLRED: begin
                            w_state_nxt  = ST_GREEN;
                            w_rem_nxt    = GT;
                            w_active_nxt = w_next_dir;
                        end
                        default: begin
                            w_state_nxt  = ST_GREEN;
                            w_rem_nxt    = GT;
                            w_active_nxt = 2'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign w_tens  = 4'(w_rem_nxt / 7'd10);
    assign w_units = 4'(w_rem_nxt % 7'd10);

    // Lamp and digit images are decoded from the next state so the output
    // registers update in the same edge as the state they describe.
    always_comb begin
        w_green  = '0;
        w_yellow = '0;
        w_red    = '1;
        w_tl     = '0;
        w_th     = '0;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (2'(k) == w_active_nxt) begin
                w_green[k]    = (w_state_nxt == ST_GREEN);
                w_yellow[k]   = (w_state_nxt == ST_YELLOW);
                w_red[k]      = !(w_green[k] || w_yellow[k]);
                w_tl[4*k +: 4] = w_units;
                w_th[4*k +: 4] = w_tens;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (R) begin
            r_state  <= ST_GREEN;
            r_rem    <= GT;
            r_active <= 2'd0;
            r_pre    <= 16'd0;
            GREEN    <= RST_G;
            YELLOW   <= '0;
            RED      <= RST_R;
            TIME_L   <= RST_TL;
            TIME_H   <= RST_TH;
            ACTIVE   <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_rem    <= w_rem_nxt;
            r_active <= w_active_nxt;
            r_pre    <= w_pre_nxt;
            GREEN    <= w_green;
            YELLOW   <= w_yellow;
            RED      <= w_red;
            TIME_L   <= w_tl;
            TIME_H   <= w_th;
            ACTIVE   <= w_active_nxt;
        end
    end

endmodule
